// File: rtl/fifo_prog.sv
// fifo_prog: synchronous FIFO with programmable almost-full/almost-empty
// thresholds, an occupancy count and sticky overflow/underflow flags.
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads;
// leave it undefined for registered reads (one-cycle read latency).
//
// Handshake: a write is accepted on a rising edge when w_req & w_ready,
// and a read when r_req & r_ready. w_ready/r_ready depend only on the
// registered count, never on the requests. A request seen while its ready
// is low is rejected: no pointer, count or memory change, only the
// matching sticky error flag is set.
module fifo_prog #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
   parameter int AE_THRESH  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  w_req,
   input  logic                  r_req,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  read_valid,
   output logic                  r_ready,
   output logic                  w_ready,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   fifo_count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 1;

   // Thresholds and depth at count width so all compares are unsigned CW-bit.
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CW-1:0]         count;
   logic                  wr_acc;
   logic                  rd_acc;

   assign w_ready      = (count != DEPTH_C);
   assign r_ready      = (count != '0);
   assign wr_acc       = w_req & w_ready;
   assign rd_acc       = r_req & r_ready;
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);
   assign fifo_count   = count;

   // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= write_data;
   end

`ifdef FIFO_FWFT_EN
   // Head word is always on the output; r_req just pops it.
   assign read_data  = mem[rd_ptr];
   assign read_valid = r_ready;
`else
   // Registered read: load the head word on an accepted read, valid for one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         read_data  <= '0;
         read_valid <= 1'b0;
      end else begin
         read_valid <= rd_acc;
         if (rd_acc) read_data <= mem[rd_ptr];
      end
   end
`endif

   // Sticky error flags; a new error in the clear cycle keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (w_req & ~w_ready) overflow <= 1'b1;
         else if (err_clr)     overflow <= 1'b0;
         if (r_req & ~r_ready) underflow <= 1'b1;
         else if (err_clr)     underflow <= 1'b0;
      end
   end

endmodule

// File: doc/fifo_prog.md
# fifo_prog

Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds, an occupancy count output and sticky overflow/underflow error flags. It is the next-generation buffer for decoupling producer/consumer stages in the accelerator datapath. It supports both registered-read and first-word-fall-through (FWFT) read modes. Handshake naming (w_req/r_req, w_ready/r_ready) is kept from the existing FIFO so instances can be swapped in directly.

## Interface

- DATA_WIDTH, 8: width of each stored word
- ADDR_WIDTH, 3: log2 of depth; DEPTH = 2^ADDR_WIDTH
- AF_THRESH, 2^ADDR_WIDTH-2: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 1: almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1

Ports:

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- w_req  in  1  write request
- r_req  in  1  read request / pop
- write_data  in  DATA_WIDTH  word to write
- err_clr  in  1  synchronous clear of overflow/underflow
- read_data  out  DATA_WIDTH  read word
- read_valid  out  1  read_data holds a valid word
- r_ready  out  1  FIFO non-empty, read will be accepted
- w_ready  out  1  FIFO not full, write will be accepted
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- fifo_count  out  ADDR_WIDTH+1  current occupancy 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation

- Storage: DEPTH x DATA_WIDTH array. Write and read pointers are ADDR_WIDTH bits and wrap modulo DEPTH. The count register is ADDR_WIDTH+1 bits wide.
- Write accepted = w_req & w_ready: store at wr_ptr, then increment wr_ptr.
- Read accepted = r_req & r_ready: increment rd_ptr.
- Count update:
  - +1 on write only
  - -1 on read only
  - unchanged when both or neither are accepted
- w_ready = (count != DEPTH); r_ready = (count != 0). Both are combinational from registered count.
- Full: w_ready=0, so a simultaneous read is accepted and the write is rejected (no pass-through).
- Empty: r_ready=0, so a simultaneous write is accepted and the read is rejected.
- almost_full and almost_empty are combinational compares on registered count. Compares are unsigned and ADDR_WIDTH+1 bits wide.
- Error flags:
  - overflow sets on w_req & ~w_ready
  - underflow sets on r_req & ~r_ready
  - err_clr clears both flags
  - a set in the same cycle as err_clr wins
- Rejected requests never change pointers, count or memory.
- Reset values: all pointers/count 0, read_data 0, read_valid 0, overflow 0, underflow 0. Resulting outputs: w_ready=1, r_ready=0, almost_empty=1 (AE_THRESH>=0), almost_full=0.
- Memory contents are not reset.

## Timing

- Write-to-visible latency: a word written at edge N is counted in fifo_count after edge N, so r_ready=1 during cycle N+1.
- Registered mode (default): on an accepted read at edge N, read_data is loaded with mem[rd_ptr] and read_valid=1 after edge N for exactly one cycle. read_data holds its value until the next accepted read.
- Back-to-back reads give one word per cycle.
- Reset is asynchronous: asserting it mid-operation clears all state immediately, regardless of clk. The first write is accepted at the first rising edge after reset deasserts.

## Configuration

- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - read_data = mem[rd_ptr] combinationally; read_valid = r_ready.
  - r_req acts as a pop/acknowledge of the displayed word.
  - A word written at edge N appears on read_data during cycle N+1 without any r_req.
- FIFO_FWFT_EN undefined: registered-read mode as described in Timing.
- Handshake, count, flags and thresholds are identical in both modes.

## Test plan

All scenarios use DATA_WIDTH=8, ADDR_WIDTH=3, AF_THRESH=6, AE_THRESH=1.

- Reset: hold reset 2 cycles -> fifo_count=0, w_ready=1, r_ready=0, almost_empty=1, almost_full=0, read_valid=0, overflow=underflow=0.
- Fill: write 0xA0..0xA7 on consecutive cycles -> almost_empty drops at count 2, almost_full rises at count 6, w_ready=0 at count 8. A 9th w_req -> overflow=1, count stays 8, memory unchanged.
- Drain (registered mode): 8 consecutive r_req -> read_data 0xA0..0xA7, each one cycle after its accepted read. A 9th r_req -> underflow=1. Then pulse err_clr -> both flags 0.
- Simultaneous read/write: at count 4, assert w_req and r_req for 12 cycles with incrementing data -> count stays 4, output order matches input order across pointer wrap. At count 8 with both asserted -> read accepted, write rejected, count 7.
- Async reset mid-operation: at count 5, pulse reset between clock edges -> count=0 and r_ready=0 immediately. Then write 0x3C and read -> 0x3C.
- FIFO_FWFT_EN: write 0x55 into an empty FIFO -> next cycle read_valid=1, read_data=0x55 with no r_req. One r_req -> read_valid=0, count 0.
